// File: rtl/lc3_io_pkg.sv
// Shared definitions for the LC-3 keyboard/display device responder.
// Holds the status-register protocol codes and the two FSM state encodings.
// No ports; imported by lc3_io_device and io_byte_fifo.
package lc3_io_pkg;

  // Status register protocol values written by host and device
  localparam logic [15:0] SR_IDLE = 16'h0000;
  localparam logic [15:0] SR_REQ  = 16'h0001;
  localparam logic [15:0] SR_DONE = 16'h0002;

  typedef enum logic [1:0] {
    K_IDLE,
    K_ACK,
    K_WAIT
  } kb_state_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_SEND,
    D_ACK,
    D_WAIT
  } dsp_state_t;

endpackage

// File: rtl/io_byte_fifo.sv
// 8-bit synchronous FIFO buffering keyboard bytes; head is read combinationally.
// Ports: i_Clk/i_Reset, i_Push + i_Push_Data, i_Pop, o_Head, o_Full, o_Empty, o_Count.
// Push into a full FIFO or pop from an empty one is ignored; count derives from pointers.
module io_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                           i_Clk,
  input  logic                           i_Reset,
  input  logic                           i_Push,
  input  logic [7:0]                     i_Push_Data,
  input  logic                           i_Pop,
  output logic [7:0]                     o_Head,
  output logic                           o_Full,
  output logic                           o_Empty,
  output logic [$clog2(DEPTH+1)-1:0]     o_Count
);
  import lc3_io_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] w_count;
  logic          w_push;
  logic          w_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign o_Full  = (w_count == PW'(DEPTH));
  assign o_Empty = (w_count == '0);
  assign o_Count = CW'(w_count);
  assign o_Head  = r_mem[r_rd_ptr[AW-1:0]];

  assign w_push = i_Push && !o_Full;
  assign w_pop  = i_Pop && !o_Empty;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_Push_Data;
  end

endmodule

// File: rtl/lc3_io_device.sv
// Device side of the LC-3 KBSR/KBDR and DSR/DDR status protocol, bridging to byte streams.
// Ports: i_Clk/i_Reset; KBSR/DSR/DDR_OUT from host registers; KBDR/KBSR/DSR external
// load values and strobes; Rx ready/valid byte input into a FIFO; Tx ready/valid output.
module lc3_io_device #(
  parameter int KB_FIFO_DEPTH = 4
) (
  input  logic                               i_Clk,
  input  logic                               i_Reset,
  input  logic [15:0]                        KBSR_OUT,
  input  logic [15:0]                        DSR_OUT,
  input  logic [15:0]                        DDR_OUT,
  output logic [15:0]                        KBDR_EXT_OUT,
  output logic [15:0]                        KBSR_EXT_OUT,
  output logic                               LD_KBSR_EXT,
  output logic [15:0]                        DSR_EXT_OUT,
  output logic                               LD_DSR_EXT,
  input  logic [7:0]                         i_Rx_Byte,
  input  logic                               i_Rx_Valid,
  output logic                               o_Rx_Ready,
  output logic [7:0]                         o_Tx_Byte,
  output logic                               o_Tx_Valid,
  input  logic                               i_Tx_Ready,
  output logic [$clog2(KB_FIFO_DEPTH+1)-1:0] o_Kb_Count
);
  import lc3_io_pkg::*;

  // ---------------- keyboard FIFO ----------------
  logic [7:0] w_fifo_head;
  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic       w_rx_push;
  logic       w_kb_fire;

  assign o_Rx_Ready = !w_fifo_full && !i_Reset;
  assign w_rx_push  = i_Rx_Valid && o_Rx_Ready;

  io_byte_fifo #(.DEPTH(KB_FIFO_DEPTH)) u_kb_fifo (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .i_Push      (w_rx_push),
    .i_Push_Data (i_Rx_Byte),
    .i_Pop       (w_kb_fire),
    .o_Head      (w_fifo_head),
    .o_Full      (w_fifo_full),
    .o_Empty     (w_fifo_empty),
    .o_Count     (o_Kb_Count)
  );

  // High byte of DDR carries nothing for the display
  logic w_unused_ddr_hi;
  assign w_unused_ddr_hi = ^DDR_OUT[15:8];

  // ---------------- keyboard FSM ----------------
  kb_state_t   r_kb_state, w_kb_next;
  logic [15:0] r_kbdr, w_kbdr_d;
  logic [15:0] r_kbsr_ext, w_kbsr_ext_d;
  logic        r_ld_kbsr, w_ld_kbsr_d;

  // A request waiting on an empty FIFO simply stays in K_IDLE until a byte lands
  assign w_kb_fire = (r_kb_state == K_IDLE) && (KBSR_OUT == SR_REQ) && !w_fifo_empty;

  always_comb begin
    w_kb_next = r_kb_state;
    case (r_kb_state)
      K_IDLE:  if (w_kb_fire) w_kb_next = K_ACK;
      K_ACK:   w_kb_next = K_WAIT;
      K_WAIT:  if (KBSR_OUT != SR_DONE) w_kb_next = K_IDLE;
      default: w_kb_next = K_IDLE;
    endcase
  end

  always_comb begin
    w_kbdr_d     = r_kbdr;
    w_kbsr_ext_d = r_kbsr_ext;
    w_ld_kbsr_d  = 1'b0;
    if (w_kb_fire) begin
      w_kbdr_d     = {8'h00, w_fifo_head};
      w_kbsr_ext_d = SR_DONE;
      w_ld_kbsr_d  = 1'b1;
    end
  end

  // ---------------- display FSM ----------------
  dsp_state_t  r_dsp_state, w_dsp_next;
  logic [7:0]  r_tx_byte, w_tx_byte_d;
  logic        r_tx_vld, w_tx_vld_d;
  logic [15:0] r_dsr_ext, w_dsr_ext_d;
  logic        r_ld_dsr, w_ld_dsr_d;

  always_comb begin
    w_dsp_next = r_dsp_state;
    case (r_dsp_state)
      D_IDLE:  if (DSR_OUT == SR_REQ) w_dsp_next = D_SEND;
      D_SEND:  if (i_Tx_Ready) w_dsp_next = D_ACK;
      D_ACK:   w_dsp_next = D_WAIT;
      D_WAIT:  if (DSR_OUT != SR_DONE) w_dsp_next = D_IDLE;
      default: w_dsp_next = D_IDLE;
    endcase
  end

  always_comb begin
    w_tx_byte_d = r_tx_byte;
    w_tx_vld_d  = r_tx_vld;
    w_dsr_ext_d = r_dsr_ext;
    w_ld_dsr_d  = 1'b0;
    case (r_dsp_state)
      D_IDLE: begin
        if (DSR_OUT == SR_REQ) begin
          w_tx_byte_d = DDR_OUT[7:0];
          w_tx_vld_d  = 1'b1;
        end
      end
      D_SEND: begin
        // Byte stays frozen while the sink stalls, even if DDR changes
        if (i_Tx_Ready) begin
          w_tx_vld_d  = 1'b0;
          w_dsr_ext_d = SR_DONE;
          w_ld_dsr_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------- state and output registers ----------------
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_kb_state  <= K_IDLE;
      r_kbdr      <= '0;
      r_kbsr_ext  <= SR_IDLE;
      r_ld_kbsr   <= 1'b0;
      r_dsp_state <= D_IDLE;
      r_tx_byte   <= '0;
      r_tx_vld    <= 1'b0;
      r_dsr_ext   <= SR_IDLE;
      r_ld_dsr    <= 1'b0;
    end else begin
      r_kb_state  <= w_kb_next;
      r_kbdr      <= w_kbdr_d;
      r_kbsr_ext  <= w_kbsr_ext_d;
      r_ld_kbsr   <= w_ld_kbsr_d;
      r_dsp_state <= w_dsp_next;
      r_tx_byte   <= w_tx_byte_d;
      r_tx_vld    <= w_tx_vld_d;
      r_dsr_ext   <= w_dsr_ext_d;
      r_ld_dsr    <= w_ld_dsr_d;
    end
  end

  assign KBDR_EXT_OUT = r_kbdr;
  assign KBSR_EXT_OUT = r_kbsr_ext;
  assign LD_KBSR_EXT  = r_ld_kbsr;
  assign DSR_EXT_OUT  = r_dsr_ext;
  assign LD_DSR_EXT   = r_ld_dsr;
  assign o_Tx_Byte    = r_tx_byte;
  assign o_Tx_Valid   = r_tx_vld;

endmodule

// File: tb/tb_lc3_io_device.sv
// Directed bench for lc3_io_device with host-side KBSR/DSR register models.
// Host writes win over device external loads, as in the real register instances.
// Inputs are driven and outputs checked 1 time unit after each rising edge.
module tb_lc3_io_device;

  logic        clk;
  logic        rst;
  logic [15:0] kbsr;
  logic [15:0] dsr;
  logic [15:0] ddr;
  logic [15:0] kbdr_ext;
  logic [15:0] kbsr_ext;
  logic        ld_kbsr;
  logic [15:0] dsr_ext;
  logic        ld_dsr;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic [2:0]  kb_count;

  logic        kb_we;
  logic [15:0] kb_val;
  logic        ds_we;
  logic [15:0] ds_val;

  int checks = 0;
  int errors = 0;

  lc3_io_device #(.KB_FIFO_DEPTH(4)) dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .KBSR_OUT     (kbsr),
    .DSR_OUT      (dsr),
    .DDR_OUT      (ddr),
    .KBDR_EXT_OUT (kbdr_ext),
    .KBSR_EXT_OUT (kbsr_ext),
    .LD_KBSR_EXT  (ld_kbsr),
    .DSR_EXT_OUT  (dsr_ext),
    .LD_DSR_EXT   (ld_dsr),
    .i_Rx_Byte    (rx_byte),
    .i_Rx_Valid   (rx_valid),
    .o_Rx_Ready   (rx_ready),
    .o_Tx_Byte    (tx_byte),
    .o_Tx_Valid   (tx_valid),
    .i_Tx_Ready   (tx_ready),
    .o_Kb_Count   (kb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Host-side status registers: host write has priority over the device load
  always @(posedge clk) begin
    if (rst) begin
      kbsr <= 16'h0000;
      dsr  <= 16'h0000;
    end else begin
      if (kb_we)        kbsr <= kb_val;
      else if (ld_kbsr) kbsr <= kbsr_ext;
      if (ds_we)        dsr <= ds_val;
      else if (ld_dsr)  dsr <= dsr_ext;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic host_kb(input logic [15:0] v);
    kb_we = 1'b1; kb_val = v;
    cyc();
    kb_we = 1'b0;
  endtask

  task automatic host_ds(input logic [15:0] v);
    ds_we = 1'b1; ds_val = v;
    cyc();
    ds_we = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    rx_valid = 1'b1; rx_byte = b;
    cyc();
    rx_valid = 1'b0;
  endtask

  // One full keyboard handshake expecting byte b at the head of the FIFO
  task automatic kb_request(input logic [7:0] b, input string tag);
    host_kb(16'h0001);
    check({tag, "_ld_pre"}, {15'd0, ld_kbsr}, 16'h0000);
    cyc();
    check({tag, "_ld"}, {15'd0, ld_kbsr}, 16'h0001);
    check({tag, "_kbsr_ext"}, kbsr_ext, 16'h0002);
    check({tag, "_kbdr"}, kbdr_ext, {8'h00, b});
    cyc();
    check({tag, "_ld_clr"}, {15'd0, ld_kbsr}, 16'h0000);
    check({tag, "_kbsr_done"}, kbsr, 16'h0002);
    host_kb(16'h0000);
    cyc();
  endtask

  // Keyboard and display strobes aligned: DSR request leads KBSR request by one
  // cycle because the display needs an extra cycle for the Tx handshake.
  task automatic both_round(input logic [7:0] b, input logic [15:0] d, input string tag);
    push(b);
    ddr = d;
    tx_ready = 1'b1;
    host_ds(16'h0001);
    host_kb(16'h0001);
    check({tag, "_txv"}, {15'd0, tx_valid}, 16'h0001);
    check({tag, "_txb"}, {8'h00, tx_byte}, {8'h00, d[7:0]});
    cyc();
    check({tag, "_ld_kb"}, {15'd0, ld_kbsr}, 16'h0001);
    check({tag, "_ld_ds"}, {15'd0, ld_dsr}, 16'h0001);
    check({tag, "_kbdr"}, kbdr_ext, {8'h00, b});
    check({tag, "_dsr_ext"}, dsr_ext, 16'h0002);
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check({tag, "_nofire_kb"}, {15'd0, ld_kbsr}, 16'h0000);
      check({tag, "_nofire_ds"}, {15'd0, ld_dsr}, 16'h0000);
      check({tag, "_nofire_txv"}, {15'd0, tx_valid}, 16'h0000);
    end
    check({tag, "_kbsr2"}, kbsr, 16'h0002);
    check({tag, "_dsr2"}, dsr, 16'h0002);
    kb_we = 1'b1; kb_val = 16'h0000;
    ds_we = 1'b1; ds_val = 16'h0000;
    cyc();
    kb_we = 1'b0; ds_we = 1'b0;
    cyc();
  endtask

  initial begin
    logic [7:0] fill [4];
    logic       fired;
    fill = '{8'h11, 8'h22, 8'h33, 8'h44};

    rst = 1'b1; ddr = 16'h0000;
    kb_we = 1'b0; kb_val = 16'h0000; ds_we = 1'b0; ds_val = 16'h0000;
    rx_byte = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;

    // Reset state
    cyc(); cyc();
    check("rst_kbdr", kbdr_ext, 16'h0000);
    check("rst_kbsr_ext", kbsr_ext, 16'h0000);
    check("rst_dsr_ext", dsr_ext, 16'h0000);
    check("rst_lds", {14'd0, ld_kbsr, ld_dsr}, 16'h0000);
    check("rst_tx", {7'd0, tx_valid, tx_byte}, 16'h0000);
    check("rst_count", {13'd0, kb_count}, 16'h0000);
    check("rst_rdy", {15'd0, rx_ready}, 16'h0000);
    rst = 1'b0;
    #1;
    check("rdy_after_rst", {15'd0, rx_ready}, 16'h0001);

    // Basic keyboard transfer
    push(8'h41);
    check("t1_count1", {13'd0, kb_count}, 16'h0001);
    kb_request(8'h41, "t1");
    check("t1_count0", {13'd0, kb_count}, 16'h0000);
    check("t1_kbdr_hold", kbdr_ext, 16'h0041);

    // Request on empty FIFO, byte arrives later
    host_kb(16'h0001);
    fired = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (ld_kbsr) fired = 1'b1;
    end
    check("t2_no_fire_empty", {15'd0, fired}, 16'h0000);
    push(8'h5A);
    check("t2_count1", {13'd0, kb_count}, 16'h0001);
    check("t2_ld_early", {15'd0, ld_kbsr}, 16'h0000);
    cyc();
    check("t2_ld", {15'd0, ld_kbsr}, 16'h0001);
    check("t2_kbdr", kbdr_ext, 16'h005A);
    check("t2_count0", {13'd0, kb_count}, 16'h0000);
    cyc();
    host_kb(16'h0000);
    cyc();

    // Fill to depth, fifth byte stalls until the first pop
    rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_byte = fill[i];
      check("t3_rdy_fill", {15'd0, rx_ready}, 16'h0001);
      cyc();
    end
    check("t3_count4", {13'd0, kb_count}, 16'h0004);
    check("t3_rdy_full", {15'd0, rx_ready}, 16'h0000);
    rx_byte = 8'h55;
    cyc();
    check("t3_count_held", {13'd0, kb_count}, 16'h0004);
    host_kb(16'h0001);
    cyc();
    check("t3_ld", {15'd0, ld_kbsr}, 16'h0001);
    check("t3_kbdr", kbdr_ext, 16'h0011);
    check("t3_count3", {13'd0, kb_count}, 16'h0003);
    check("t3_rdy_again", {15'd0, rx_ready}, 16'h0001);
    cyc();
    rx_valid = 1'b0;
    check("t3_fifth_in", {13'd0, kb_count}, 16'h0004);
    host_kb(16'h0000);
    cyc();
    kb_request(8'h22, "t3b");
    kb_request(8'h33, "t3c");
    kb_request(8'h44, "t3d");
    kb_request(8'h55, "t3e");
    check("t3_empty", {13'd0, kb_count}, 16'h0000);

    // Display with stalled sink
    ddr = 16'hAB63;
    tx_ready = 1'b0;
    host_ds(16'h0001);
    check("t4_txv_pre", {15'd0, tx_valid}, 16'h0000);
    cyc();
    check("t4_txv", {15'd0, tx_valid}, 16'h0001);
    check("t4_txb", {8'h00, tx_byte}, 16'h0063);
    ddr = 16'hCD12;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t4_hold_txb", {8'h00, tx_byte}, 16'h0063);
      check("t4_hold_txv", {15'd0, tx_valid}, 16'h0001);
      check("t4_hold_ld", {15'd0, ld_dsr}, 16'h0000);
    end
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    check("t4_ld", {15'd0, ld_dsr}, 16'h0001);
    check("t4_dsr_ext", dsr_ext, 16'h0002);
    check("t4_txv_clr", {15'd0, tx_valid}, 16'h0000);
    cyc();
    check("t4_ld_clr", {15'd0, ld_dsr}, 16'h0000);
    check("t4_dsr2", dsr, 16'h0002);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t4_nofire", {14'd0, ld_dsr, tx_valid}, 16'h0000);
    end
    host_ds(16'h0000);
    cyc();

    // Simultaneous strobes, no re-fire, then re-arm
    both_round(8'h77, 16'h0042, "t5a");
    both_round(8'h78, 16'h0099, "t5b");

    // Reset mid-transaction
    push(8'hC1);
    push(8'hC2);
    ddr = 16'h0011;
    tx_ready = 1'b0;
    host_ds(16'h0001);
    cyc();
    check("t6_txv_inflight", {15'd0, tx_valid}, 16'h0001);
    check("t6_count2", {13'd0, kb_count}, 16'h0002);
    rst = 1'b1;
    #1;
    check("t6_rdy_in_rst", {15'd0, rx_ready}, 16'h0000);
    cyc();
    rst = 1'b0;
    check("t6_txv0", {15'd0, tx_valid}, 16'h0000);
    check("t6_count0", {13'd0, kb_count}, 16'h0000);
    check("t6_kbdr0", kbdr_ext, 16'h0000);
    check("t6_txb0", {8'h00, tx_byte}, 16'h0000);
    fired = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (ld_kbsr || ld_dsr || tx_valid) fired = 1'b1;
    end
    check("t6_no_strobe", {15'd0, fired}, 16'h0000);
    both_round(8'h3C, 16'h0055, "t6r");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
